// File: rtl/nios_cpu_mul_sequencer.sv
// Sequential 32x32 multiplier built from one pipelined 16x16 unsigned multiplier.
// The 64-bit unsigned sum is sign-corrected at the end to serve mul/mulxuu/mulxsu/mulxss.
module nios_cpu_mul_sequencer #(
    parameter int MUL_LAT = 1,
    parameter bit LO_SKIP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_src1,
    input  logic [31:0] E_src2,
    input  logic [1:0]  op,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    // Handshake: start is accepted in any cycle where busy=0 (IDLE or DONE);
    // done pulses for one cycle with result valid and busy low in that cycle.
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] a_q, b_q;
    logic [1:0]  op_q;
    logic [63:0] acc;
    logic [1:0]  k;
    logic        acc_last;

    logic [31:0]        pp_q [MUL_LAT];
    logic [1:0]         sh_q [MUL_LAT];
    logic [MUL_LAT-1:0] vld_q;
    logic [MUL_LAT-1:0] last_q;

    logic        accept, issue, issue_last;
    logic [1:0]  k_last;
    logic [15:0] a_h, b_h;
    logic [5:0]  shamt;
    logic [63:0] pp_ext;
    logic [31:0] hi_fix;

    assign accept     = start && (state == IDLE || state == DONE);
    assign issue      = (state == ISSUE);
    assign k_last     = (op_q == 2'd0 && LO_SKIP) ? 2'd2 : 2'd3;
    assign issue_last = issue && (k == k_last);

    // k[1] selects the A halfword, k[0] the B halfword.
    assign a_h = k[1] ? a_q[31:16] : a_q[15:0];
    assign b_h = k[0] ? b_q[31:16] : b_q[15:0];

    assign shamt  = (sh_q[MUL_LAT-1] == 2'd0) ? 6'd0 :
                    (sh_q[MUL_LAT-1] == 2'd3) ? 6'd32 : 6'd16;
    assign pp_ext = {32'd0, pp_q[MUL_LAT-1]} << shamt;

    // The unsigned high word over-counts by B when A is negative and by A when B is negative.
    assign hi_fix = acc[63:32]
                  - ((op_q[1] && a_q[31]) ? b_q : 32'd0)
                  - ((op_q == 2'd3 && b_q[31]) ? a_q : 32'd0);

    assign busy = (state == ISSUE) || (state == DRAIN) || (state == FIX);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (issue_last) state_nxt = DRAIN;
            DRAIN:   if (acc_last) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = start ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            acc      <= '0;
            k        <= '0;
            acc_last <= 1'b0;
            result   <= '0;
            vld_q    <= '0;
            last_q   <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                pp_q[i] <= '0;
                sh_q[i] <= '0;
            end
        end else begin
            state <= state_nxt;

            pp_q[0]   <= {16'd0, a_h} * {16'd0, b_h};
            sh_q[0]   <= k;
            vld_q[0]  <= issue;
            last_q[0] <= issue_last;
            for (int i = 1; i < MUL_LAT; i++) begin
                pp_q[i]   <= pp_q[i-1];
                sh_q[i]   <= sh_q[i-1];
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
            end

            if (accept) begin
                a_q      <= E_src1;
                b_q      <= E_src2;
                op_q     <= op;
                acc      <= '0;
                k        <= '0;
                acc_last <= 1'b0;
            end else begin
                if (issue) k <= k + 2'd1;
                if (vld_q[MUL_LAT-1]) begin
                    acc <= acc + pp_ext;
                    if (last_q[MUL_LAT-1]) acc_last <= 1'b1;
                end
            end

            if (state == FIX) result <= (op_q == 2'd0) ? acc[31:0] : hi_fix;
        end
    end
endmodule
